// File: rtl/process_scheduler_if.sv
// Processor/PCB-facing bus of the round-robin scheduler.
// The master drives the CPU/PCB side inputs; the slave is the scheduler itself.
interface process_scheduler_if #(
    parameter int PID_W = 5
);
    logic             proc_load;
    logic [PID_W-1:0] load_pid;
    logic             yield_req;
    logic             exit_req;
    logic [31:0]      cpu_pc;
    logic [31:0]      pcb_rdata;
    logic             pcb_we;
    logic [PID_W-1:0] pcb_pid;
    logic [31:0]      pcb_wdata;
    logic             cpu_hold;
    logic             cpu_load_pc;
    logic [31:0]      cpu_new_pc;
    logic [PID_W-1:0] cur_pid;
    logic             idle;

    modport master (
        output proc_load, load_pid, yield_req, exit_req, cpu_pc, pcb_rdata,
        input  pcb_we, pcb_pid, pcb_wdata, cpu_hold, cpu_load_pc, cpu_new_pc,
               cur_pid, idle
    );

    modport slave (
        input  proc_load, load_pid, yield_req, exit_req, cpu_pc, pcb_rdata,
        output pcb_we, pcb_pid, pcb_wdata, cpu_hold, cpu_load_pc, cpu_new_pc,
               cur_pid, idle
    );
endinterface

// File: rtl/process_scheduler.sv
// Round-robin scheduler: preempts on a fixed quantum, on yield or on exit, and
// swaps the running PC out to / in from the process control block.
module process_scheduler #(
    parameter int NUM_PROC = 8,
    parameter int PID_W    = 5,
    parameter int QUANTUM  = 16
) (
    input logic               clk,
    input logic               reset,
    process_scheduler_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_PROC);
    localparam int CNT_W = $clog2(QUANTUM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SAVE,
        S_SELECT,
        S_RESTORE,
        S_LOAD
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_PROC-1:0] alive_q, alive_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PID_W-1:0]   cur_pid_q, cur_pid_d;
    logic [PID_W-1:0]   next_pid_q, next_pid_d;
    logic               exit_flag_q, exit_flag_d;
    logic               cpu_load_pc_q, cpu_load_pc_d;
    logic [31:0]        cpu_new_pc_q, cpu_new_pc_d;

    logic [NUM_PROC-1:0] load_hit;
    logic [NUM_PROC-1:0] exit_hit;

    // Per-slot decode; an exit clears the bit after a same-cycle load sets it.
    for (genvar gi = 0; gi < NUM_PROC; gi++) begin : g_slot
        assign load_hit[gi] = bus.proc_load && (bus.load_pid == PID_W'(gi));
        assign exit_hit[gi] = (state_q == S_RUN) && bus.exit_req &&
                              (cur_pid_q == PID_W'(gi));
    end

    // Circular search: rotate the mask so bit 0 is cur_pid+1, then pick the
    // lowest set bit; cur_pid itself lands in the last position.
    logic [IDX_W-1:0]      cur_idx;
    logic [IDX_W:0]        start_off;
    logic [2*NUM_PROC-1:0] alive_dbl;
    logic [NUM_PROC-1:0]   rot;
    logic [IDX_W-1:0]      hit_off;
    logic                  found;
    logic [IDX_W:0]        hit_sum;
    logic [IDX_W:0]        sel_full;

    assign cur_idx   = cur_pid_q[IDX_W-1:0];
    assign start_off = {1'b0, cur_idx} + (IDX_W+1)'(1);
    assign alive_dbl = {alive_q, alive_q};
    assign rot       = NUM_PROC'(alive_dbl >> start_off);
    assign found     = |rot;

    always_comb begin
        hit_off = '0;
        for (int i = NUM_PROC - 1; i >= 0; i--) begin
            if (rot[i]) hit_off = IDX_W'(i);
        end
    end

    assign hit_sum  = start_off + {1'b0, hit_off};
    assign sel_full = (hit_sum >= (IDX_W+1)'(NUM_PROC)) ?
                      hit_sum - (IDX_W+1)'(NUM_PROC) : hit_sum;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cur_pid_d     = cur_pid_q;
        next_pid_d    = next_pid_q;
        exit_flag_d   = exit_flag_q;
        cpu_load_pc_d = 1'b0;
        cpu_new_pc_d  = cpu_new_pc_q;
        alive_d       = (alive_q | load_hit) & ~exit_hit;

        case (state_q)
            S_IDLE: begin
                // Looking at the incoming load lets startup reach SELECT next cycle.
                if (|alive_d) state_d = S_SELECT;
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.exit_req) begin
                    exit_flag_d = 1'b1;
                    state_d     = S_SAVE;
                end else if (bus.yield_req || (cnt_q == CNT_W'(QUANTUM - 1))) begin
                    exit_flag_d = 1'b0;
                    state_d     = S_SAVE;
                end
            end
            S_SAVE: begin
                state_d = S_SELECT;
            end
            S_SELECT: begin
                if (found) begin
                    next_pid_d = PID_W'(sel_full);
                    state_d    = S_RESTORE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RESTORE: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                cpu_load_pc_d = 1'b1;
                cpu_new_pc_d  = bus.pcb_rdata;
                cur_pid_d     = next_pid_q;
                cnt_d         = '0;
                state_d       = S_RUN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            alive_q       <= '0;
            cnt_q         <= '0;
            cur_pid_q     <= '0;
            next_pid_q    <= '0;
            exit_flag_q   <= 1'b0;
            cpu_load_pc_q <= 1'b0;
            cpu_new_pc_q  <= '0;
        end else begin
            state_q       <= state_d;
            alive_q       <= alive_d;
            cnt_q         <= cnt_d;
            cur_pid_q     <= cur_pid_d;
            next_pid_q    <= next_pid_d;
            exit_flag_q   <= exit_flag_d;
            cpu_load_pc_q <= cpu_load_pc_d;
            cpu_new_pc_q  <= cpu_new_pc_d;
        end
    end

    assign bus.idle        = (state_q == S_IDLE);
    assign bus.cpu_hold    = (state_q != S_RUN);
    assign bus.pcb_we      = (state_q == S_SAVE) && !exit_flag_q;
    assign bus.pcb_pid     = (state_q == S_RESTORE) ? next_pid_q : cur_pid_q;
    assign bus.pcb_wdata   = (state_q == S_SAVE) ? bus.cpu_pc : 32'h0;
    assign bus.cpu_load_pc = cpu_load_pc_q;
    assign bus.cpu_new_pc  = cpu_new_pc_q;
    assign bus.cur_pid     = cur_pid_q;
endmodule

// File: tb/tb_process_scheduler.sv
// Scoreboard bench: stimulus queues expected PCB writes and CPU PC loads, a
// negedge monitor pops and compares each one the scheduler presents.
module tb_process_scheduler;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    process_scheduler_if #(.PID_W(5)) bus ();

    process_scheduler #(
        .NUM_PROC(8),
        .PID_W   (5),
        .QUANTUM (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        logic        is_write;
        logic [4:0]  pid;
        logic [31:0] data;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // PCB model: synchronous single-port store, read data one cycle later.
    logic [31:0] pcb_mem [0:31];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) pcb_mem[i] <= 32'h0;
            pcb_mem[0] <= 32'h100;
            pcb_mem[1] <= 32'h200;
            pcb_mem[2] <= 32'h300;
            pcb_mem[3] <= 32'h3000;
            pcb_mem[5] <= 32'h500;
        end else if (bus.pcb_we) begin
            pcb_mem[bus.pcb_pid] <= bus.pcb_wdata;
        end
        bus.pcb_rdata <= pcb_mem[bus.pcb_pid];
    end

    // CPU model: loads on the strobe, otherwise advances by 4 when not held.
    always @(posedge clk) begin
        if (reset)                bus.cpu_pc <= 32'h0;
        else if (bus.cpu_load_pc) bus.cpu_pc <= bus.cpu_new_pc;
        else if (!bus.cpu_hold)   bus.cpu_pc <= bus.cpu_pc + 32'd4;
    end

    always @(negedge clk) begin
        if (!reset && (bus.pcb_we || bus.cpu_load_pc)) begin
            logic [4:0]  act_pid;
            logic [31:0] act_data;
            txn_t        t;
            act_pid  = bus.pcb_we ? bus.pcb_pid : bus.cur_pid;
            act_data = bus.pcb_we ? bus.pcb_wdata : bus.cpu_new_pc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_txn write=%0b pid=%0d data=%h required no transaction",
                         bus.pcb_we, act_pid, act_data);
            end else begin
                t = exp_q.pop_front();
                if (t.is_write !== bus.pcb_we || t.pid !== act_pid || t.data !== act_data) begin
                    errors++;
                    $display("FAIL txn got write=%0b pid=%0d data=%h required write=%0b pid=%0d data=%h",
                             bus.pcb_we, act_pid, act_data, t.is_write, t.pid, t.data);
                end else begin
                    $display("txn %s pid=%0d pc=%h", t.is_write ? "save" : "load", t.pid, t.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic w, input logic [4:0] pid, input logic [31:0] data);
        txn_t t;
        t.is_write = w;
        t.pid      = pid;
        t.data     = data;
        exp_q.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, req);
        end
    endtask

    task automatic wait_load(input logic [4:0] pid, output int n);
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (bus.cpu_load_pc && bus.cur_pid == pid) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_load timeout for pid %0d", pid);
    endtask

    initial begin
        int n;
        int holds;
        reset         = 1'b1;
        bus.proc_load = 1'b0;
        bus.load_pid  = '0;
        bus.yield_req = 1'b0;
        bus.exit_req  = 1'b0;
        repeat (3) tick();

        chk("rst_idle",        32'(bus.idle), 32'd1);
        chk("rst_hold",        32'(bus.cpu_hold), 32'd1);
        chk("rst_pcb_we",      32'(bus.pcb_we), 32'd0);
        chk("rst_pcb_wdata",   bus.pcb_wdata, 32'h0);
        chk("rst_load_pc",     32'(bus.cpu_load_pc), 32'd0);
        chk("rst_new_pc",      bus.cpu_new_pc, 32'h0);
        chk("rst_cur_pid",     32'(bus.cur_pid), 32'd0);
        reset = 1'b0;
        tick();

        // Round robin 0->1->2->0->1 with a yield on PID 1's third RUN cycle.
        push(0, 0, 32'h100);  push(1, 0, 32'h13C);
        push(0, 1, 32'h200);  push(1, 1, 32'h208);
        push(0, 2, 32'h300);  push(1, 2, 32'h33C);
        push(0, 0, 32'h13C);  push(1, 0, 32'h178);
        push(0, 1, 32'h208);
        bus.proc_load = 1'b1; bus.load_pid = 5'd0; tick();
        bus.load_pid = 5'd1; tick();
        bus.load_pid = 5'd2; tick();
        bus.proc_load = 1'b0;
        wait_load(5'd0, n);
        chk("startup_latency", 32'(n), 32'd1);
        wait_load(5'd1, n);
        tick(); tick();
        bus.yield_req = 1'b1; tick();
        bus.yield_req = 1'b0;
        chk("yield_save_we",  32'(bus.pcb_we), 32'd1);
        chk("yield_save_pid", 32'(bus.pcb_pid), 32'd1);
        wait_load(5'd2, n);
        chk("switch_latency", 32'(n), 32'd4);
        wait_load(5'd0, n);
        wait_load(5'd1, n);

        // Exit+yield together is an exit; then the last two processes exit.
        push(0, 2, 32'h33C);
        tick();
        bus.exit_req = 1'b1; bus.yield_req = 1'b1; tick();
        bus.exit_req = 1'b0; bus.yield_req = 1'b0;
        chk("exit1_no_save", 32'(bus.pcb_we), 32'd0);
        wait_load(5'd2, n);
        push(0, 0, 32'h178);
        tick();
        bus.exit_req = 1'b1; tick();
        bus.exit_req = 1'b0;
        chk("exit2_no_save", 32'(bus.pcb_we), 32'd0);
        wait_load(5'd0, n);
        tick();
        bus.exit_req = 1'b1; tick();
        bus.exit_req = 1'b0;
        repeat (3) tick();
        chk("all_exit_idle", 32'(bus.idle), 32'd1);
        chk("all_exit_hold", 32'(bus.cpu_hold), 32'd1);

        // Sole PID 3 is saved and restored to itself across the wrap.
        push(0, 3, 32'h3000); push(1, 3, 32'h303C); push(0, 3, 32'h303C);
        bus.proc_load = 1'b1; bus.load_pid = 5'd3; tick();
        bus.proc_load = 1'b0;
        wait_load(5'd3, n);
        wait_load(5'd3, n);

        // PID 5 joins, then exits in the same cycle it is reloaded.
        push(1, 3, 32'h3078); push(0, 5, 32'h500);
        tick();
        bus.proc_load = 1'b1; bus.load_pid = 5'd5; tick();
        bus.proc_load = 1'b0;
        wait_load(5'd5, n);
        push(0, 3, 32'h3078);
        tick();
        bus.exit_req = 1'b1; bus.proc_load = 1'b1; bus.load_pid = 5'd5; tick();
        bus.exit_req = 1'b0; bus.proc_load = 1'b0;
        chk("exit_load_no_save", 32'(bus.pcb_we), 32'd0);
        wait_load(5'd3, n);
        push(1, 3, 32'h30B4); push(0, 3, 32'h30B4);
        wait_load(5'd3, n);

        // Yield held into SAVE must produce exactly one switch.
        push(1, 3, 32'h30B8); push(0, 3, 32'h30B8);
        tick();
        bus.yield_req = 1'b1; tick(); tick();
        bus.yield_req = 1'b0;
        wait_load(5'd3, n);
        chk("yield_in_save_latency", 32'(n), 32'd3);
        holds = 0;
        repeat (10) begin
            tick();
            if (bus.cpu_hold) holds++;
        end
        chk("no_second_switch", 32'(holds), 32'd0);

        // Reset in RESTORE aborts the switch.
        push(1, 3, 32'h30E0);
        bus.yield_req = 1'b1; tick();
        bus.yield_req = 1'b0;
        tick(); tick();
        chk("restore_pid", 32'(bus.pcb_pid), 32'd3);
        reset = 1'b1; tick();
        chk("rst_mid_idle",    32'(bus.idle), 32'd1);
        chk("rst_mid_hold",    32'(bus.cpu_hold), 32'd1);
        chk("rst_mid_load_pc", 32'(bus.cpu_load_pc), 32'd0);
        chk("rst_mid_cur_pid", 32'(bus.cur_pid), 32'd0);
        reset = 1'b0;
        repeat (5) tick();
        chk("rst_alive_clear", 32'(bus.idle), 32'd1);
        chk("queue_drained",   32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
